moore_bit_serializer: RTL

//  Upstream feeder for the Moore sequence detector: accepts parallel words over valid/ready, emits one bit per clk on ser_bit.
//  ser_bit drives the detector's X input; bit_valid marks live bits. Lets benches/SoC feed detector streams from byte sources.

---
 rtl/moore_ser_pkg.sv | 18 +
 rtl/moore_ser_shreg.sv | 40 ++++
 rtl/moore_bit_serializer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/moore_ser_pkg.sv
// Shared encodings for the Moore bit serializer: FSM state type and counter sizing.
package moore_ser_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_PARITY = 2'd2,
      S_GAP    = 2'd3
   } ser_state_e;

   // Gap counter covers GAP up to 15.
   localparam int unsigned GAP_W = 4;

   function automatic int unsigned cnt_w(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/moore_ser_shreg.sv
// Load/shift register for the serializer; exposes the first bit of an incoming word and the bit
// that becomes current after the next shift.
module moore_ser_shreg
   import moore_ser_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             first_bit_o,
   output logic             next_bit_o
);

   logic [WIDTH-1:0] data_q, data_d;

   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = din_i;
      end else if (shift_i) begin
         data_d = (MSB_FIRST != 0) ? {data_q[WIDTH-2:0], 1'b0} : {1'b0, data_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign first_bit_o = (MSB_FIRST != 0) ? din_i[WIDTH-1] : din_i[0];
   assign next_bit_o  = (MSB_FIRST != 0) ? data_q[WIDTH-2] : data_q[1];

endmodule

// File: rtl/moore_bit_serializer.sv
// Parallel-to-serial feeder for the Moore sequence detector, valid/ready input, one bit per clock.
// Define SER_PARITY_EN to append an even-parity bit after each word.
module moore_bit_serializer
   import moore_ser_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = 1,
   parameter int unsigned GAP       = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             ser_bit,
   output logic             bit_valid,
   output logic             busy
);

   localparam int unsigned CNT_W = cnt_w(WIDTH);

   ser_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             ser_bit_q, ser_bit_d;
   logic             bit_valid_q, bit_valid_d;
   logic             busy_q, busy_d;
   logic             load, shift, first_bit, next_bit, last_cycle, xfer;
`ifdef SER_PARITY_EN
   logic             par_q, par_d;
`endif

   moore_ser_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk_i       (clk),
      .rst_i       (rst),
      .load_i      (load),
      .shift_i     (shift),
      .din_i       (din),
      .first_bit_o (first_bit),
      .next_bit_o  (next_bit)
   );

`ifdef SER_PARITY_EN
   assign last_cycle = (state_q == S_PARITY);
`else
   assign last_cycle = (state_q == S_SHIFT) && (cnt_q == '0);
`endif

   // Ready in the final bit cycle lets the next word follow with no bubble.
   assign din_ready = !rst && ((state_q == S_IDLE) || ((GAP == 0) && last_cycle));
   assign xfer      = din_valid && din_ready;
   assign load      = xfer;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
      ser_bit_d   = 1'b0;
      bit_valid_d = 1'b0;
      shift       = 1'b0;
`ifdef SER_PARITY_EN
      par_d       = par_q;
`endif
      unique case (state_q)
         S_SHIFT: begin
            if (cnt_q != '0) begin
               shift       = 1'b1;
               cnt_d       = cnt_q - 1'b1;
               ser_bit_d   = next_bit;
               bit_valid_d = 1'b1;
            end
`ifdef SER_PARITY_EN
            else begin
               state_d     = S_PARITY;
               ser_bit_d   = par_q;
               bit_valid_d = 1'b1;
            end
`endif
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: ;
      endcase

      if (last_cycle) begin
         if (GAP != 0) begin
            state_d = S_GAP;
            gap_d   = GAP_W'(GAP - 1);
         end else begin
            state_d = S_IDLE;
         end
      end

      if (xfer) begin
         state_d     = S_SHIFT;
         cnt_d       = CNT_W'(WIDTH - 1);
         ser_bit_d   = first_bit;
         bit_valid_d = 1'b1;
`ifdef SER_PARITY_EN
         par_d       = ^din;
`endif
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         gap_q       <= '0;
         ser_bit_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SER_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         ser_bit_q   <= ser_bit_d;
         bit_valid_q <= bit_valid_d;
         busy_q      <= busy_d;
`ifdef SER_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   assign ser_bit   = ser_bit_q;
   assign bit_valid = bit_valid_q;
   assign busy      = busy_q;

endmodule
